// File: rtl/dmem_load_unit_if.sv
// dmem_load_unit_if: request, dmem read and response signals of the load unit
interface dmem_load_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_memop;
   logic        dmem_rd;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   modport slave (
      input  req_valid, req_addr, req_memop, dmem_rdata, rsp_ready,
      output req_ready, dmem_rd, dmem_addr, rsp_valid, rsp_data, rsp_err
   );
   modport master (
      output req_valid, req_addr, req_memop, dmem_rdata, rsp_ready,
      input  req_ready, dmem_rd, dmem_addr, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/dmem_load_unit.sv
// dmem_load_unit: issues word reads to dmem and returns aligned, extended load data
module dmem_load_unit #(
   parameter int RD_LAT = 1
) (
   input logic             clk,
   input logic             rst,
   dmem_load_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t      r_state, w_next;
   logic [1:0]  r_off;
   logic [2:0]  r_op;
   logic [1:0]  r_cnt;
   logic [31:0] r_dmem_addr;
   logic [31:0] r_data;
   logic        r_err;
   logic        w_acc;
   logic        w_bad;
   logic        w_sample;
   logic [15:0] w_sh;
   logic [31:0] w_aligned;
   assign w_acc    = bus.req_valid & bus.req_ready;
   assign w_bad    = !(bus.req_memop inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                   | (bus.req_memop[1:0] == 2'b01 && bus.req_addr[0])
                   | (bus.req_memop == 3'b010 && bus.req_addr[1:0] != 2'b00);
   assign w_sample = (r_state == WAIT) && (r_cnt == 2'd0);
   assign w_sh     = 16'(bus.dmem_rdata >> {r_off, 3'b000});
   assign w_aligned = r_op == 3'b000 ? {{24{w_sh[7]}}, w_sh[7:0]}
                    : r_op == 3'b100 ? {24'b0, w_sh[7:0]}
                    : r_op == 3'b001 ? {{16{w_sh[15]}}, w_sh}
                    : r_op == 3'b101 ? {16'b0, w_sh}
                    : bus.dmem_rdata;
   // req_ready is forced low while reset is asserted
   assign bus.req_ready = (r_state == IDLE) & ~rst;
   assign bus.dmem_rd   = r_state == ISSUE;
   assign bus.dmem_addr = r_dmem_addr;
   assign bus.rsp_valid = r_state == RESP;
   assign bus.rsp_data  = r_data;
   assign bus.rsp_err   = r_err;
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   // next state: bad requests skip the read and go straight to the response
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  w_next = w_acc ? (w_bad ? RESP : ISSUE) : IDLE;
         ISSUE: w_next = WAIT;
         WAIT:  w_next = r_cnt == 2'd0 ? RESP : WAIT;
         RESP:  w_next = bus.rsp_ready ? IDLE : RESP;
      endcase
   end
   // request latch, latency counter and response capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_off       <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_dmem_addr <= '0;
         r_data      <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_acc) begin
            r_off  <= bus.req_addr[1:0];
            r_op   <= bus.req_memop;
            r_err  <= w_bad;
            r_data <= '0;
            if (!w_bad) r_dmem_addr <= {bus.req_addr[31:2], 2'b00};
         end
         if (r_state == ISSUE) r_cnt <= 2'(RD_LAT - 1);
         else if (r_state == WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
         if (w_sample) r_data <= w_aligned;
      end
   end
endmodule

// File: tb/tb_dmem_load_unit.sv
// tb_dmem_load_unit: directed load vectors against RD_LAT=1 and RD_LAT=3 instances
module tb_dmem_load_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   dmem_load_unit_if b1 ();
   dmem_load_unit_if b3 ();
   dmem_load_unit #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   dmem_load_unit #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
   logic [31:0] mem_word = 32'h80817F01;
   logic        v1 = 1'b0;
   logic [2:0]  v3 = 3'b000;
   int          n_vec = 0;
   int          n_err = 0;
   // dmem model: data valid exactly RD_LAT cycles after the read strobe, junk otherwise
   always @(posedge clk) begin
      v1 <= b1.dmem_rd;
      v3 <= {v3[1:0], b3.dmem_rd};
   end
   assign b1.dmem_rdata = v1 ? mem_word : 32'hDEADBEEF;
   assign b3.dmem_rdata = v3[2] ? mem_word : 32'hDEADBEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready1(input string tag);
      int k;
      k = 0;
      while (!b1.req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_rdy"}, 32'(b1.req_ready), 32'd1);
   endtask

   task automatic load1(input string tag, input logic [31:0] addr, input logic [2:0] op,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
      int k, nrd;
      logic [31:0] waddr;
      waddr = {addr[31:2], 2'b00};
      @(negedge clk);
      wait_ready1(tag);
      b1.req_valid = 1'b1;
      b1.req_addr  = addr;
      b1.req_memop = op;
      @(posedge clk);
      #1 b1.req_valid = 1'b0;
      nrd = 0;
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (b1.dmem_rd) nrd++;
         if (b1.rsp_valid) break;
      end
      chk({tag, "_lat"}, 32'(k), exp_e ? 32'd1 : 32'd3);
      chk({tag, "_data"}, b1.rsp_data, exp_d);
      chk({tag, "_err"}, 32'(b1.rsp_err), 32'(exp_e));
      chk({tag, "_nrd"}, 32'(nrd), exp_e ? 32'd0 : 32'd1);
      if (!exp_e) chk({tag, "_daddr"}, b1.dmem_addr, waddr);
      for (int h = 0; h < hold; h++) begin
         b1.req_valid = 1'b1;
         b1.req_addr  = 32'h0000_0100;
         b1.req_memop = 3'b010;
         @(negedge clk);
         chk({tag, "_hold_v"}, 32'(b1.rsp_valid), 32'd1);
         chk({tag, "_hold_d"}, b1.rsp_data, exp_d);
         chk({tag, "_hold_rdy"}, 32'(b1.req_ready), 32'd0);
      end
      b1.rsp_ready = 1'b1;
      @(posedge clk);
      #1 b1.rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_drop_v"}, 32'(b1.rsp_valid), 32'd0);
      chk({tag, "_post_rdy"}, 32'(b1.req_ready), 32'd1);
      b1.req_valid = 1'b0;
   endtask

   initial begin
      int k, nrd;
      b1.req_valid = 1'b0; b1.req_addr = '0; b1.req_memop = '0; b1.rsp_ready = 1'b0;
      b3.req_valid = 1'b0; b3.req_addr = '0; b3.req_memop = '0; b3.rsp_ready = 1'b0;
      #2;
      chk("rst_rdy",   32'(b1.req_ready), 32'd0);
      chk("rst_valid", 32'(b1.rsp_valid), 32'd0);
      chk("rst_rd",    32'(b1.dmem_rd),   32'd0);
      chk("rst_addr",  b1.dmem_addr,      32'd0);
      chk("rst_data",  b1.rsp_data,       32'd0);
      chk("rst_err",   32'(b1.rsp_err),   32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      load1("lb103",  32'h103, 3'b000, 32'hFFFFFF80, 1'b0, 0);
      load1("lbu103", 32'h103, 3'b100, 32'h00000080, 1'b0, 0);
      load1("lb100",  32'h100, 3'b000, 32'h00000001, 1'b0, 0);
      load1("lh102",  32'h102, 3'b001, 32'hFFFF8081, 1'b0, 0);
      load1("lhu100", 32'h100, 3'b101, 32'h00007F01, 1'b0, 0);
      load1("lw100",  32'h100, 3'b010, 32'h80817F01, 1'b0, 0);
      load1("lw102",  32'h102, 3'b010, 32'h00000000, 1'b1, 0);
      load1("lh101",  32'h101, 3'b001, 32'h00000000, 1'b1, 0);
      load1("op111",  32'h100, 3'b111, 32'h00000000, 1'b1, 0);
      load1("lhu103", 32'h103, 3'b101, 32'h00000000, 1'b1, 0);
      load1("hold",   32'h102, 3'b101, 32'h00008081, 1'b0, 5);
      // RD_LAT=3 instance
      mem_word = 32'h12345678;
      @(negedge clk);
      k = 0;
      while (!b3.req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("l3_rdy", 32'(b3.req_ready), 32'd1);
      b3.req_valid = 1'b1; b3.req_addr = 32'h101; b3.req_memop = 3'b100;
      @(posedge clk);
      #1 b3.req_valid = 1'b0;
      nrd = 0;
      for (k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (b3.dmem_rd) nrd++;
         if (b3.rsp_valid) break;
      end
      chk("l3_lat",   32'(k),            32'd5);
      chk("l3_nrd",   32'(nrd),          32'd1);
      chk("l3_data",  b3.rsp_data,       32'h00000056);
      chk("l3_err",   32'(b3.rsp_err),   32'd0);
      chk("l3_daddr", b3.dmem_addr,      32'h100);
      b3.rsp_ready = 1'b1;
      @(posedge clk);
      #1 b3.rsp_ready = 1'b0;
      @(negedge clk);
      chk("l3_drop_v", 32'(b3.rsp_valid), 32'd0);
      // reset in the middle of a load
      mem_word = 32'h80817F01;
      @(negedge clk);
      wait_ready1("mid");
      b1.req_valid = 1'b1; b1.req_addr = 32'h100; b1.req_memop = 3'b000;
      @(posedge clk);
      #1 b1.req_valid = 1'b0;
      @(negedge clk);
      chk("mid_issue", 32'(b1.dmem_rd), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rdy",   32'(b1.req_ready), 32'd0);
      chk("mid_valid", 32'(b1.rsp_valid), 32'd0);
      chk("mid_rd",    32'(b1.dmem_rd),   32'd0);
      chk("mid_addr",  b1.dmem_addr,      32'd0);
      chk("mid_data",  b1.rsp_data,       32'd0);
      chk("mid_err",   32'(b1.rsp_err),   32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_noresp", 32'(b1.rsp_valid), 32'd0);
      end
      load1("post_lw", 32'h100, 3'b010, 32'h80817F01, 1'b0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
